// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // addi x0, x0, 0; fetch substitutes this while the pipe is being flushed.
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Instruction-memory request/grant/response bus plus the fetch-side valid/ready port.
interface inst_prefetch_buffer_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc,
    output imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; any DEPTH >= 1, head readable combinationally from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word fetches, queues {pc, inst} for the fetch
// stage, and on a redirect flushes the queue and drops the responses still in flight.
module inst_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  inst_prefetch_buffer_if.master bus
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q, discard_d;

  logic            issue, grant, resp, q_push, q_pop;
  logic [31:0]     occupancy;
  fetch_entry_t    q_wdata, q_head;
  logic [QW-1:0]   q_count;
  logic            q_full, q_empty;
  logic [XLEN-1:0] tag_rdata;
  logic [TW-1:0]   tag_count;
  logic            tag_full, tag_empty;
  logic            unused_sig;

  // Slots already promised to the queue: held entries plus live (non-stale) requests.
  assign occupancy = 32'(q_count) + 32'(outstanding_q) - 32'(discard_q);
  assign issue     = reset_n && !redirect_valid && (occupancy < DEPTH)
                     && (32'(outstanding_q) < MAX_OUTSTANDING);
  assign grant     = issue && bus.imem_gnt;
  assign resp      = bus.imem_rvalid && (outstanding_q != '0);

  assign q_push  = resp && (discard_q == '0) && !redirect_valid;
  assign q_pop   = !q_empty && bus.out_ready;
  assign q_wdata = '{pc: tag_rdata, inst: bus.imem_rdata};

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = !q_empty;
  assign bus.out_pc    = q_empty ? '0 : q_head.pc;
  assign bus.out_inst  = q_empty ? '0 : q_head.inst;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (q_push),
    .pop     (q_pop),
    .flush   (redirect_valid),
    .wdata   (q_wdata),
    .rdata   (q_head),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Tags survive a redirect so every stale response still retires its own tag.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_pc_q (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (grant),
    .pop     (resp),
    .flush   (1'b0),
    .wdata   (fetch_pc_q),
    .rdata   (tag_rdata),
    .count   (tag_count),
    .full    (tag_full),
    .empty   (tag_empty)
  );

  assign unused_sig = ^{redirect_pc[1:0], tag_count, tag_full, tag_empty, q_full};

  always_comb begin
    outstanding_d = outstanding_q + OW'(grant) - OW'(resp);
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    if (redirect_valid) begin
      discard_d  = outstanding_d;
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (resp && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifndef SYNTHESIS
  rvalid_without_request: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.imem_rvalid && (outstanding_q == '0)));
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed vector bench for inst_prefetch_buffer with an in-order latency-configurable memory.
module tb_inst_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int passed = 0;
  int total  = 0;
  int mem_lat = 1;
  int cyc = 0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  inst_prefetch_buffer_if bus ();

  inst_prefetch_buffer #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a << 5) | 32'h0000_0013;
  endfunction

  // In-order memory: a granted address answers mem_lat cycles after its grant.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      cyc <= 0;
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (bus.imem_req && bus.imem_gnt) begin
        mem_addr_q.push_back(bus.imem_addr);
        mem_due_q.push_back(cyc + mem_lat - 1);
      end
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= inst_of(mem_addr_q[0]);
        mem_addr_q.pop_front();
        mem_due_q.pop_front();
      end else begin
        bus.imem_rvalid <= 1'b0;
        bus.imem_rdata  <= '0;
      end
    end
  end

  typedef struct {
    logic        rst;
    int          lat;
    logic        ready;
    logic        gnt;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input int lat, input logic ready, input logic gnt,
                     input logic redir, input logic [31:0] rpc, input logic ev,
                     input logic [31:0] epc, input logic ereq, input logic [31:0] eaddr);
    vec_t v;
    v = '{rst, lat, ready, gnt, redir, rpc, ev, epc, ereq, eaddr};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset(input int lat);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    mem_lat        = lat;
    repeat (2) @(posedge clk);
    #1;
    check("reset imem_req", 32'(bus.imem_req), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_inst", bus.out_inst, 32'd0);
    check("reset out_pc", bus.out_pc, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.imem_gnt  = 1'b1;
    bus.out_ready = 1'b1;

    // Streaming, single-cycle memory.
    add(1, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h0);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h4);
    add(0, 1, 1, 1, 0, 0, 1, 32'h0,  1, 32'h8);
    add(0, 1, 1, 1, 0, 0, 1, 32'h4,  1, 32'hC);
    add(0, 1, 1, 1, 0, 0, 1, 32'h8,  1, 32'h10);
    add(0, 1, 1, 1, 0, 0, 1, 32'hC,  1, 32'h14);
    // Stall 10 cycles: queue fills to 4, requests stop, then drain in order.
    add(1, 1, 0, 1, 0, 0, 0, 32'h0,  1, 32'h0);
    add(0, 1, 0, 1, 0, 0, 0, 32'h0,  1, 32'h4);
    add(0, 1, 0, 1, 0, 0, 1, 32'h0,  1, 32'h8);
    add(0, 1, 0, 1, 0, 0, 1, 32'h0,  1, 32'hC);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h0,  0, 32'h0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h4,  1, 32'h10);
    add(0, 1, 1, 1, 0, 0, 1, 32'h8,  1, 32'h14);
    add(0, 1, 1, 1, 0, 0, 1, 32'hC,  1, 32'h18);
    add(0, 1, 1, 1, 0, 0, 1, 32'h10, 1, 32'h1C);
    // Redirect to 0x100 with two requests outstanding (two-cycle memory).
    add(1, 2, 1, 1, 0, 0, 0, 32'h0,  1, 32'h0);
    add(0, 2, 1, 1, 0, 0, 0, 32'h0,  1, 32'h4);
    add(0, 2, 1, 1, 1, 32'h100, 0, 32'h0, 0, 32'h0);
    add(0, 2, 1, 1, 0, 0, 0, 32'h0,  1, 32'h100);
    add(0, 2, 1, 1, 0, 0, 0, 32'h0,  1, 32'h104);
    add(0, 2, 1, 1, 0, 0, 0, 32'h0,  0, 32'h0);
    add(0, 2, 1, 1, 0, 0, 1, 32'h100, 1, 32'h108);
    add(0, 2, 1, 1, 0, 0, 1, 32'h104, 1, 32'h10C);
    // Unaligned redirect coinciding with a pop.
    add(1, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h0);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h4);
    add(0, 1, 1, 1, 1, 32'h203, 1, 32'h0, 0, 32'h0);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h200);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h204);
    add(0, 1, 1, 1, 0, 0, 1, 32'h200, 1, 32'h208);
    add(0, 1, 1, 1, 0, 0, 1, 32'h204, 1, 32'h20C);
    // Grant withheld at 0x10, then a redirect while still withheld.
    add(1, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h0);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h4);
    add(0, 1, 1, 1, 0, 0, 1, 32'h0,  1, 32'h8);
    add(0, 1, 1, 1, 0, 0, 1, 32'h4,  1, 32'hC);
    add(0, 1, 1, 0, 0, 0, 1, 32'h8,  1, 32'h10);
    add(0, 1, 1, 0, 0, 0, 1, 32'hC,  1, 32'h10);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,  1, 32'h10);
    add(0, 1, 1, 0, 1, 32'h300, 0, 32'h0, 0, 32'h0);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h300);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h304);
    add(0, 1, 1, 1, 0, 0, 1, 32'h300, 1, 32'h308);
    // Address wrap past 0xFFFF_FFFC.
    add(1, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h0);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h4);
    add(0, 1, 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h0, 0, 32'h0);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'hFFFF_FFFC);
    add(0, 1, 1, 1, 0, 0, 0, 32'h0,  1, 32'h0);
    add(0, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h4);
    add(0, 1, 1, 1, 0, 0, 1, 32'h0,  1, 32'h8);
    add(0, 1, 1, 1, 0, 0, 1, 32'h4,  1, 32'hC);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset(vecs[i].lat);
      bus.out_ready  = vecs[i].ready;
      bus.imem_gnt   = vecs[i].gnt;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d out_pc", i), bus.out_pc, vecs[i].ev ? vecs[i].epc : 32'h0);
      check($sformatf("row%0d out_inst", i), bus.out_inst,
            vecs[i].ev ? inst_of(vecs[i].epc) : 32'h0);
      check($sformatf("row%0d imem_req", i), 32'(bus.imem_req), 32'(vecs[i].ereq));
      if (vecs[i].ereq) check($sformatf("row%0d imem_addr", i), bus.imem_addr, vecs[i].eaddr);
      @(posedge clk);
      #1;
    end

    // Reset mid-burst clears the output asynchronously, before any clock edge.
    redirect_valid = 1'b0;
    #1;
    check("preburst out_valid", 32'(bus.out_valid), 32'd1);
    check("preburst out_pc", bus.out_pc, 32'h8);
    #1;
    reset_n = 1'b0;
    #1;
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    check("async out_pc", bus.out_pc, 32'h0);
    check("async imem_req", 32'(bus.imem_req), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
